sum_sync_arbiter: RTL and testbench
===================================

// Module: sum_sync_arbiter
// PURPOSE
//  Per-pixel charge-summing synchroniser, successor to the combinational sum/winner gate.
//  Detects a rising edge on the local summing discriminator and opens a programmable coincidence window.
//  During the window it collects unmasked neighbour discriminators and the winner-take-all flag.
//  Emits a fixed-width sumPulse to the pixel counter only if the event is won; otherwise enters dead time.
//  Sits between the pixel discriminator front-end and the counter; provides bypass mode when sync is disabled.
// PARAMETERS
//  NUM_NB     8  number of neighbour summing discriminators (3x3 neighbourhood)
//  WIN_W      4  width of winLen (window length in clk cycles)
//  PULSE_CYC  2  sumPulse high time in clk cycles (>=1)
//  CNT_W      8  width of rejectCnt (PILEUP_CNT_EN only)
// PORTS
//  clk                  in   1       pixel clock; all inputs synchronous to it
//  rst                  in   1       synchronous, active-high reset
//  discOutSumLocal      in   1       local summing discriminator
//  discOutSumNeighbour  in   NUM_NB  neighbour summing discriminators
//  nbMask               in   NUM_NB  1 = neighbour ignored (edge/dead pixel)
//  syncEnable           in   1       1 = arbitration mode, 0 = bypass
//  winerAll             in   1       winner-take-all result for this pixel
//  winLen               in   WIN_W   window length in cycles; 0 treated as 1
//  sumPulse             out  1       registered count pulse to counter
//  busy                 out  1       high in WINDOW/PULSE/DEAD
//  rejectCnt            out  CNT_W   saturating rejected-event count (PILEUP_CNT_EN only)
// BEHAVIOUR
//  - One clock; reset synchronous active-high. On rst: state=IDLE, sumPulse=0, busy=0, all sticky flags=0,
//    window/pulse counters=0, localDly=0, rejectCnt=0.
//  - Edge detect: localRise = discOutSumLocal & ~localDly; localDly registered every cycle (also in bypass).
//  - Bypass (syncEnable=0): state forced to IDLE next cycle; sumPulse <= discOutSumLocal (1-cycle latency);
//    busy=0; no arbitration, rejectCnt unchanged.
//  - States (syncEnable=1):
//    IDLE   : on localRise -> WINDOW, winCnt <= max(winLen,1)-1, stickies cleared then loaded with this cycle's inputs.
//    WINDOW : nbSeen[i] |= discOutSumNeighbour[i]; winSeen |= winerAll; winCnt decrements.
//             When winCnt==0 evaluate pass = winSeen & &(nbSeen | nbMask) (includes current-cycle inputs).
//             pass -> PULSE; fail -> DEAD.
//    PULSE  : sumPulse=1 for exactly PULSE_CYC cycles, first high cycle is the cycle after evaluation; then -> DEAD.
//    DEAD   : sumPulse=0; stays until discOutSumLocal==0 sampled, then -> IDLE (minimum 1 cycle).
//  - Latency: localRise at cycle 0, winLen=N -> evaluation at cycle N-1, sumPulse high cycles N..N+PULSE_CYC-1.
//  - All-masked neighbours: coincidence term is 1; pass depends only on winSeen.
//  - localRise during WINDOW/PULSE/DEAD is ignored (no retrigger, no window extension).
//  - winLen sampled only on entry to WINDOW; changes mid-window have no effect.
//  - syncEnable 1->0 mid-WINDOW/PULSE/DEAD: abort to IDLE next cycle, any pulse truncated; bypass applies.
//  - syncEnable 0->1 while local high: no localRise pending -> stays IDLE until next rising edge.
//  - rst mid-operation: immediate return to reset values next edge; partially issued pulse truncated.
// CONFIGURATION
//  PILEUP_CNT_EN defined: rejectCnt increments by 1 on each WINDOW->DEAD (fail) transition,
//    saturates at 2**CNT_W-1, cleared only by rst; port present.
//  PILEUP_CNT_EN undefined: no counter, rejectCnt port absent; all other behaviour identical.
// TESTING
//  1 rst=1 3 cycles, random inputs -> sumPulse=0, busy=0, rejectCnt=0 throughout.
//  2 syncEnable=0, local high cycles 5..9 -> sumPulse high cycles 6..10, busy=0.
//  3 syncEnable=1, winLen=4, nbMask=0, all nb high cycle 2, winerAll high cycle 3, local rise cycle 0
//    -> sumPulse high cycles 4..5 (PULSE_CYC=2), DEAD until local low.
//  4 Same as 3 but nb[5] never high -> no sumPulse, rejectCnt=1; with nbMask[5]=1 -> pass.
//  5 winLen=0, all inputs high with local rise cycle 0 -> sumPulse high cycles 1..2.
//  6 Second local rise during PULSE, then syncEnable=0 mid-WINDOW of next event -> no retrigger, FSM IDLE next cycle.

Source files
------------

// File: rtl/sum_sync_arbiter.sv
// Per-pixel charge-summing synchroniser: opens a coincidence window on a local rising edge and
// emits a fixed-width count pulse only if the event is won. Optional reject counter: PILEUP_CNT_EN.
module sum_sync_arbiter #(
  parameter int NUM_NB    = 8,
  parameter int WIN_W     = 4,
  parameter int PULSE_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              discOutSumLocal,
  input  logic [NUM_NB-1:0] discOutSumNeighbour,
  input  logic [NUM_NB-1:0] nbMask,
  input  logic              syncEnable,
  input  logic              winerAll,
  input  logic [WIN_W-1:0]  winLen,
  output logic              sumPulse,
  output logic              busy
`ifdef PILEUP_CNT_EN
  ,
  output logic [CNT_W-1:0]  rejectCnt
`endif
);

  localparam int PC_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  if (PULSE_CYC < 1) begin : g_pulse_cyc_check
    $error("PULSE_CYC must be >= 1");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WINDOW, PULSE, DEAD} state_t;

  state_t            state_q, state_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [PC_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [NUM_NB-1:0] nb_seen_q, nb_seen_d;
  logic              win_seen_q, win_seen_d;
  logic              local_dly_q, local_dly_d;
  logic              sum_pulse_q, sum_pulse_d;
  logic              busy_q, busy_d;

  logic              local_rise;
  logic [WIN_W-1:0]  win_len_eff;
  logic [NUM_NB-1:0] nb_now;
  logic [NUM_NB-1:0] nb_ok;
  logic              win_now;
  logic              pass;
  logic              evaluate;
  logic              fail;

  assign local_rise  = discOutSumLocal & ~local_dly_q;
  assign win_len_eff = (winLen == '0) ? WIN_W'(1) : winLen;

  // Stickies restart from this cycle's inputs on window entry, accumulate while in WINDOW.
  assign nb_now  = (state_q == WINDOW) ? (nb_seen_q | discOutSumNeighbour) : discOutSumNeighbour;
  assign win_now = (state_q == WINDOW) ? (win_seen_q | winerAll) : winerAll;

  genvar gi;
  for (gi = 0; gi < NUM_NB; gi++) begin : g_nb_ok
    assign nb_ok[gi] = nb_now[gi] | nbMask[gi];
  end

  assign pass = win_now & (&nb_ok);

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    nb_seen_d   = nb_seen_q;
    win_seen_d  = win_seen_q;
    local_dly_d = discOutSumLocal;
    sum_pulse_d = 1'b0;
    evaluate    = 1'b0;
    fail        = 1'b0;

    if (!syncEnable) begin
      state_d     = IDLE;
      sum_pulse_d = discOutSumLocal;
      win_cnt_d   = '0;
      pulse_cnt_d = '0;
      nb_seen_d   = '0;
      win_seen_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (local_rise) begin
            nb_seen_d  = nb_now;
            win_seen_d = win_now;
            // A one-cycle window is decided in the rise cycle itself.
            if (win_len_eff == WIN_W'(1)) begin
              evaluate = 1'b1;
            end else begin
              state_d   = WINDOW;
              win_cnt_d = win_len_eff - WIN_W'(1);
            end
          end
        end
        WINDOW: begin
          nb_seen_d  = nb_now;
          win_seen_d = win_now;
          win_cnt_d  = win_cnt_q - WIN_W'(1);
          if (win_cnt_q == WIN_W'(1)) evaluate = 1'b1;
        end
        PULSE: begin
          if (pulse_cnt_q == '0) begin
            state_d = DEAD;
          end else begin
            pulse_cnt_d = pulse_cnt_q - PC_W'(1);
            sum_pulse_d = 1'b1;
          end
        end
        DEAD: begin
          if (!discOutSumLocal) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (evaluate) begin
        if (pass) begin
          state_d     = PULSE;
          sum_pulse_d = 1'b1;
          pulse_cnt_d = PC_W'(PULSE_CYC - 1);
        end else begin
          state_d = DEAD;
          fail    = 1'b1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      nb_seen_q   <= '0;
      win_seen_q  <= 1'b0;
      local_dly_q <= 1'b0;
      sum_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      nb_seen_q   <= nb_seen_d;
      win_seen_q  <= win_seen_d;
      local_dly_q <= local_dly_d;
      sum_pulse_q <= sum_pulse_d;
      busy_q      <= busy_d;
    end
  end

  assign sumPulse = sum_pulse_q;
  assign busy     = busy_q;

`ifdef PILEUP_CNT_EN
  logic [CNT_W-1:0] reject_cnt_q, reject_cnt_d;

  always_comb begin
    reject_cnt_d = reject_cnt_q;
    if (fail && (reject_cnt_q != '1)) reject_cnt_d = reject_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) reject_cnt_q <= '0;
    else     reject_cnt_q <= reject_cnt_d;
  end

  assign rejectCnt = reject_cnt_q;
`else
  logic unused_fail;
  assign unused_fail = fail;
`endif

endmodule

// File: tb/tb_sum_sync_arbiter.sv
// Directed-vector bench for sum_sync_arbiter: bypass, pass/fail arbitration, masking,
// zero window length, no-retrigger and mid-window abort. Build with PILEUP_CNT_EN to check rejectCnt.
module tb_sum_sync_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       discOutSumLocal;
  logic [7:0] discOutSumNeighbour;
  logic [7:0] nbMask;
  logic       syncEnable;
  logic       winerAll;
  logic [3:0] winLen;
  logic       sumPulse;
  logic       busy;
`ifdef PILEUP_CNT_EN
  logic [7:0] rejectCnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sum_sync_arbiter #(.NUM_NB(8), .WIN_W(4), .PULSE_CYC(2), .CNT_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .discOutSumLocal     (discOutSumLocal),
    .discOutSumNeighbour (discOutSumNeighbour),
    .nbMask              (nbMask),
    .syncEnable          (syncEnable),
    .winerAll            (winerAll),
    .winLen              (winLen),
    .sumPulse            (sumPulse),
    .busy                (busy)
`ifdef PILEUP_CNT_EN
    ,
    .rejectCnt           (rejectCnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check outputs mid-cycle.
  task automatic step(input string tag, input logic loc, input logic [7:0] nb, input logic win,
                      input logic sync, input logic ep, input logic eb);
    discOutSumLocal     = loc;
    discOutSumNeighbour = nb;
    winerAll            = win;
    syncEnable          = sync;
    @(negedge clk);
    chk({tag, " pulse"}, {31'd0, sumPulse}, {31'd0, ep});
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, eb});
    @(posedge clk);
    #1;
  endtask

  // Local rise at cycle 0, local high for loc_len cycles; empty ranges use lo > hi.
  task automatic run_event(input string tag, input int wl, input logic [7:0] msk,
                           input logic [7:0] nbv, input int nb_c, input int win_c,
                           input int loc_len, input int ncyc,
                           input int p_lo, input int p_hi, input int b_lo, input int b_hi);
    winLen = 4'(wl);
    nbMask = msk;
    for (int k = 0; k < ncyc; k++) begin
      step($sformatf("%s c%0d", tag, k), (k < loc_len), (k == nb_c) ? nbv : 8'h00,
           (k == win_c), 1'b1, (k >= p_lo && k <= p_hi), (k >= b_lo && k <= b_hi));
    end
    $display("event %s: checks=%0d errors=%0d", tag, n_checks, n_errors);
  endtask

  initial begin
    rst                 = 1'b1;
    discOutSumLocal     = 1'b0;
    discOutSumNeighbour = 8'h00;
    nbMask              = 8'h00;
    syncEnable          = 1'b1;
    winerAll            = 1'b0;
    winLen              = 4'd4;
    @(posedge clk);
    #1;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      discOutSumLocal     = 1'($urandom);
      discOutSumNeighbour = 8'($urandom);
      nbMask              = 8'($urandom);
      syncEnable          = 1'($urandom);
      winerAll            = 1'($urandom);
      winLen              = 4'($urandom);
      @(negedge clk);
      chk($sformatf("rst c%0d pulse", i), {31'd0, sumPulse}, 32'd0);
      chk($sformatf("rst c%0d busy", i), {31'd0, busy}, 32'd0);
`ifdef PILEUP_CNT_EN
      chk($sformatf("rst c%0d rejectCnt", i), {24'd0, rejectCnt}, 32'd0);
`endif
      @(posedge clk);
      #1;
    end
    rst    = 1'b0;
    nbMask = 8'h00;
    winLen = 4'd4;
    $display("event reset: checks=%0d errors=%0d", n_checks, n_errors);

    // Bypass: local high 5..9 -> pulse high 6..10, never busy.
    for (int k = 0; k < 12; k++) begin
      step($sformatf("bypass c%0d", k), (k >= 5 && k <= 9), 8'h00, 1'b0, 1'b0,
           (k >= 6 && k <= 10), 1'b0);
    end
    $display("event bypass: checks=%0d errors=%0d", n_checks, n_errors);

    //         tag        wl  mask   nbv    nb wn loc ncyc plo phi blo bhi
    run_event("win4_pass", 4, 8'h00, 8'hFF, 2, 3, 8, 11,  4,  5,  1,  8);
    run_event("win4_nb5",  4, 8'h00, 8'hDF, 2, 3, 8, 11,  1,  0,  1,  8);
`ifdef PILEUP_CNT_EN
    chk("rejectCnt after nb5 fail", {24'd0, rejectCnt}, 32'd1);
`endif
    run_event("win4_mask5", 4, 8'h20, 8'hDF, 2, 3, 8, 11, 4,  5,  1,  8);
`ifdef PILEUP_CNT_EN
    chk("rejectCnt after mask5 pass", {24'd0, rejectCnt}, 32'd1);
`endif
    run_event("win0",      0, 8'h00, 8'hFF, 0, 0, 3,  6,  1,  2,  1,  3);
    run_event("allmask_w", 2, 8'hFF, 8'h00, 0, 1, 2,  7,  2,  3,  1,  4);
    run_event("allmask_n", 2, 8'hFF, 8'h00, 0, -1, 2, 5,  1,  0,  1,  2);
`ifdef PILEUP_CNT_EN
    chk("rejectCnt after allmask fail", {24'd0, rejectCnt}, 32'd2);
`endif

    // No retrigger during PULSE, then sync dropped mid-WINDOW of the next event.
    winLen = 4'd2;
    nbMask = 8'hFF;
    step("retrig c0",  1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    step("retrig c1",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step("retrig c2",  1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    step("retrig c3",  1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    step("retrig c4",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    winLen = 4'd4;
    step("retrig c5",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step("abort c6",   1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step("abort c7",   1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    step("abort c8",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step("abort c9",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("abort c10",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step("abort c11",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("event retrig_abort: checks=%0d errors=%0d", n_checks, n_errors);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
